// File: rtl/memory_access_unit_pkg.sv
// Shared definitions for the memory-access stage.
// - FSM state encoding (IDLE / WAIT / RESP)
// - err_cause codes reported to the write-back side
// - default data/address widths
// - word-alignment helper used on the byte address from execute
package memory_access_unit_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } err_cause_e;

  function automatic logic word_aligned(input logic [1:0] byte_lsb);
    return (byte_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/memory_access_unit_timeout_counter.sv
// Wait-cycle counter for an outstanding memory request.
// Ports:
//   clk     - clock
//   rst     - synchronous reset, active-low
//   clear   - force the count to zero (used whenever no request is pending)
//   enable  - count one cycle of waiting
//   expired - count has reached TIMEOUT-1
module mem_timeout_counter
  import memory_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  assign expired = (count_q == 8'(TIMEOUT - 1));

  // Saturate at the expiry value so the flag stays up until cleared.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable && !expired) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-access stage between execute and register write-back.
// Non-memory instructions are forwarded with one cycle of latency; aligned
// loads/stores run a req/ack handshake with data memory; misaligned accesses
// and memory timeouts produce a faulting result packet and a sticky error.
// Ports:
//   clk, rst                  - clock, synchronous active-low reset
//   in_valid / in_ready       - transfer handshake from execute
//   in_isLd/isSt/isWb/isCall  - instruction class and control flags
//   in_aluResult, in_stData   - ALU result (byte address for ld/st), store data
//   in_rd, in_pc              - destination register, instruction PC
//   mem_req/we/addr/wdata     - data-memory request (held stable in WAIT)
//   mem_rdata, mem_ack        - data-memory response
//   out_valid + out_*         - one-cycle result packet to write-back
//   mem_err, err_cause        - sticky fault flag and first fault cause
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_isLd,
  input  logic              in_isSt,
  input  logic              in_isWb,
  input  logic              in_isCall,
  input  logic [DATA_W-1:0] in_aluResult,
  input  logic [DATA_W-1:0] in_stData,
  input  logic [3:0]        in_rd,
  input  logic [DATA_W-1:0] in_pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_aluResult,
  output logic [DATA_W-1:0] out_ldResult,
  output logic [3:0]        out_rd,
  output logic              out_isWb,
  output logic              out_isLd,
  output logic              out_isCall,
  output logic [DATA_W-1:0] out_pc,
  output logic              mem_err,
  output logic [1:0]        err_cause
);

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Packet of the memory op in flight; copied to out_* only when it retires
  // so out_* keep showing the previous result while the request is pending.
  logic [DATA_W-1:0] p_alu_q, p_alu_d;
  logic [DATA_W-1:0] p_ld_q, p_ld_d;
  logic [DATA_W-1:0] p_pc_q, p_pc_d;
  logic [3:0]        p_rd_q, p_rd_d;
  logic              p_iswb_q, p_iswb_d;
  logic              p_isld_q, p_isld_d;
  logic              p_iscall_q, p_iscall_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_alu_q, out_alu_d;
  logic [DATA_W-1:0] out_ld_q, out_ld_d;
  logic [DATA_W-1:0] out_pc_q, out_pc_d;
  logic [3:0]        out_rd_q, out_rd_d;
  logic              out_iswb_q, out_iswb_d;
  logic              out_isld_q, out_isld_d;
  logic              out_iscall_q, out_iscall_d;

  logic              err_q, err_d;
  logic [1:0]        cause_q, cause_d;

  logic              expired;
  logic              is_mem;
  logic              aligned;

  mem_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != ST_WAIT),
    .enable (state_q == ST_WAIT),
    .expired(expired)
  );

  assign is_mem  = in_isLd | in_isSt;
  assign aligned = word_aligned(in_aluResult[1:0]);

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    p_alu_d      = p_alu_q;
    p_ld_d       = p_ld_q;
    p_pc_d       = p_pc_q;
    p_rd_d       = p_rd_q;
    p_iswb_d     = p_iswb_q;
    p_isld_d     = p_isld_q;
    p_iscall_d   = p_iscall_q;
    out_valid_d  = 1'b0;
    out_alu_d    = out_alu_q;
    out_ld_d     = out_ld_q;
    out_pc_d     = out_pc_q;
    out_rd_d     = out_rd_q;
    out_iswb_d   = out_iswb_q;
    out_isld_d   = out_isld_q;
    out_iscall_d = out_iscall_q;
    err_d        = err_q;
    cause_d      = cause_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!is_mem || !aligned) begin
            // Retire immediately: plain pass-through, or misaligned fault
            // which suppresses write-back and never touches memory.
            out_valid_d  = 1'b1;
            out_alu_d    = in_aluResult;
            out_ld_d     = '0;
            out_pc_d     = in_pc;
            out_rd_d     = in_rd;
            out_iswb_d   = is_mem ? 1'b0 : in_isWb;
            out_isld_d   = in_isLd;
            out_iscall_d = in_isCall;
            if (is_mem) begin
              err_d = 1'b1;
              if (cause_q == ERR_NONE) cause_d = ERR_MISALIGN;
            end
          end else begin
            p_alu_d     = in_aluResult;
            p_ld_d      = '0;
            p_pc_d      = in_pc;
            p_rd_d      = in_rd;
            p_iswb_d    = in_isWb;
            p_isld_d    = in_isLd;
            p_iscall_d  = in_isCall;
            mem_req_d   = 1'b1;
            // Load+store together is treated as a load.
            mem_we_d    = in_isSt & ~in_isLd;
            mem_addr_d  = in_aluResult[ADDR_W+1:2];
            mem_wdata_d = in_stData;
            state_d     = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // Ack is checked first so an ack on the expiry cycle is not a fault.
        if (mem_ack) begin
          p_ld_d    = p_isld_q ? mem_rdata : '0;
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end else if (expired) begin
          p_ld_d    = '0;
          p_iswb_d  = 1'b0;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (cause_q == ERR_NONE) cause_d = ERR_TIMEOUT;
          state_d   = ST_RESP;
        end
      end

      ST_RESP: begin
        out_valid_d  = 1'b1;
        out_alu_d    = p_alu_q;
        out_ld_d     = p_ld_q;
        out_pc_d     = p_pc_q;
        out_rd_d     = p_rd_q;
        out_iswb_d   = p_iswb_q;
        out_isld_d   = p_isld_q;
        out_iscall_d = p_iscall_q;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      p_alu_q      <= '0;
      p_ld_q       <= '0;
      p_pc_q       <= '0;
      p_rd_q       <= '0;
      p_iswb_q     <= 1'b0;
      p_isld_q     <= 1'b0;
      p_iscall_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_alu_q    <= '0;
      out_ld_q     <= '0;
      out_pc_q     <= '0;
      out_rd_q     <= '0;
      out_iswb_q   <= 1'b0;
      out_isld_q   <= 1'b0;
      out_iscall_q <= 1'b0;
      err_q        <= 1'b0;
      cause_q      <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      p_alu_q      <= p_alu_d;
      p_ld_q       <= p_ld_d;
      p_pc_q       <= p_pc_d;
      p_rd_q       <= p_rd_d;
      p_iswb_q     <= p_iswb_d;
      p_isld_q     <= p_isld_d;
      p_iscall_q   <= p_iscall_d;
      out_valid_q  <= out_valid_d;
      out_alu_q    <= out_alu_d;
      out_ld_q     <= out_ld_d;
      out_pc_q     <= out_pc_d;
      out_rd_q     <= out_rd_d;
      out_iswb_q   <= out_iswb_d;
      out_isld_q   <= out_isld_d;
      out_iscall_q <= out_iscall_d;
      err_q        <= err_d;
      cause_q      <= cause_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign out_valid     = out_valid_q;
  assign out_aluResult = out_alu_q;
  assign out_ldResult  = out_ld_q;
  assign out_pc        = out_pc_q;
  assign out_rd        = out_rd_q;
  assign out_isWb      = out_iswb_q;
  assign out_isLd      = out_isld_q;
  assign out_isCall    = out_iscall_q;
  assign mem_err       = err_q;
  assign err_cause     = cause_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit (TIMEOUT=4). Expected result packets
// are queued when an instruction is driven and checked when out_valid fires.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_isLd, in_isSt, in_isWb, in_isCall;
  logic [31:0] in_aluResult, in_stData, in_pc;
  logic [3:0]  in_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        out_valid, out_isWb, out_isLd, out_isCall, mem_err;
  logic [31:0] out_aluResult, out_ldResult, out_pc;
  logic [3:0]  out_rd;
  logic [1:0]  err_cause;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc;
    logic [3:0]  rd;
    logic        wb;
    logic        isld;
    logic        call;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  memory_access_unit #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_isLd(in_isLd), .in_isSt(in_isSt), .in_isWb(in_isWb), .in_isCall(in_isCall),
    .in_aluResult(in_aluResult), .in_stData(in_stData), .in_rd(in_rd), .in_pc(in_pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_valid(out_valid), .out_aluResult(out_aluResult), .out_ldResult(out_ldResult),
    .out_rd(out_rd), .out_isWb(out_isWb), .out_isLd(out_isLd), .out_isCall(out_isCall),
    .out_pc(out_pc), .mem_err(mem_err), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] st, input logic [31:0] pc,
                       input logic [3:0] rd, input logic ld, input logic sto,
                       input logic wb, input logic call,
                       input logic [31:0] exp_ld, input logic exp_wb);
    exp_t e;
    in_valid = 1'b1; in_aluResult = alu; in_stData = st; in_pc = pc; in_rd = rd;
    in_isLd = ld; in_isSt = sto; in_isWb = wb; in_isCall = call;
    e.alu = alu; e.ld = exp_ld; e.pc = pc; e.rd = rd; e.wb = exp_wb; e.isld = ld; e.call = call;
    exp_q.push_back(e);
    $display("drive: alu=%08h ld=%0b st=%0b wb=%0b call=%0b rd=%0d pc=%08h", alu, ld, sto, wb, call, rd, pc);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_isLd = 1'b0; in_isSt = 1'b0; in_isWb = 1'b0; in_isCall = 1'b0;
  endtask

  // Scoreboard: every result strobe must match the oldest queued packet.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("result: alu=%08h ld=%08h rd=%0d wb=%0b isld=%0b call=%0b pc=%08h",
                 out_aluResult, out_ldResult, out_rd, out_isWb, out_isLd, out_isCall, out_pc);
        chk("sb_alu", {32'd0, out_aluResult}, {32'd0, e.alu});
        chk("sb_ld", {32'd0, out_ldResult}, {32'd0, e.ld});
        chk("sb_pc", {32'd0, out_pc}, {32'd0, e.pc});
        chk("sb_rd", {60'd0, out_rd}, {60'd0, e.rd});
        chk("sb_iswb", {63'd0, out_isWb}, {63'd0, e.wb});
        chk("sb_isld", {63'd0, out_isLd}, {63'd0, e.isld});
        chk("sb_iscall", {63'd0, out_isCall}, {63'd0, e.call});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0; in_stData = '0; in_aluResult = '0;
    in_pc = '0; in_rd = '0;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mem_err", {63'd0, mem_err}, 64'd0);
    chk("rst_err_cause", {62'd0, err_cause}, 64'd0);
    chk("rst_mem_addr", {48'd0, mem_addr}, 64'd0);
    chk("rst_out_alu", {32'd0, out_aluResult}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b1;
    @(negedge clk);

    // Single non-memory op
    drive(32'h1234, 32'h0, 32'h100, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk); idle();
    chk("nm_out_valid", {63'd0, out_valid}, 64'd1);
    chk("nm_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    chk("nm_strobe_one_cycle", {63'd0, out_valid}, 64'd0);
    chk("nm_hold_alu", {32'd0, out_aluResult}, 64'h1234);

    // Three back-to-back ops, one a call
    drive(32'h1, 32'h0, 32'h104, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("b2b_valid0", {63'd0, out_valid}, 64'd1);
    drive(32'h2, 32'h0, 32'h108, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1);
    @(negedge clk);
    chk("b2b_valid1", {63'd0, out_valid}, 64'd1);
    drive(32'h3, 32'h0, 32'h10c, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk); idle();
    chk("b2b_valid2", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    chk("b2b_done", {63'd0, out_valid}, 64'd0);

    // Ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk); mem_ack = 1'b0;
    chk("stray_ack_valid", {63'd0, out_valid}, 64'd0);
    chk("stray_ack_req", {63'd0, mem_req}, 64'd0);

    // Load: ack on third WAIT cycle
    drive(32'h10, 32'h0, 32'h200, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk); idle();
    chk("ld_req", {63'd0, mem_req}, 64'd1);
    chk("ld_addr", {48'd0, mem_addr}, 64'd4);
    chk("ld_we", {63'd0, mem_we}, 64'd0);
    chk("ld_ready0", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("ld_req2", {63'd0, mem_req}, 64'd1);
    chk("ld_ready1", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("ld_req3", {63'd0, mem_req}, 64'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("ld_req_drop", {63'd0, mem_req}, 64'd0);
    chk("ld_ready_resp", {63'd0, in_ready}, 64'd0);
    chk("ld_not_yet_valid", {63'd0, out_valid}, 64'd0);
    chk("ld_out_hold", {32'd0, out_aluResult}, 64'h3);
    @(negedge clk);
    chk("ld_valid", {63'd0, out_valid}, 64'd1);

    // Store: ack on first WAIT cycle
    drive(32'h8, 32'hA5A5_A5A5, 32'h300, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk); idle();
    chk("st_req", {63'd0, mem_req}, 64'd1);
    chk("st_we", {63'd0, mem_we}, 64'd1);
    chk("st_wdata", {32'd0, mem_wdata}, 64'hA5A5_A5A5);
    chk("st_addr", {48'd0, mem_addr}, 64'd2);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk); mem_ack = 1'b0;
    chk("st_req_drop", {63'd0, mem_req}, 64'd0);
    chk("st_no_valid_yet", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("st_valid", {63'd0, out_valid}, 64'd1);

    // Misaligned load
    drive(32'h13, 32'h0, 32'h400, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk); idle();
    chk("mis_req", {63'd0, mem_req}, 64'd0);
    chk("mis_valid", {63'd0, out_valid}, 64'd1);
    chk("mis_err", {63'd0, mem_err}, 64'd1);
    chk("mis_cause", {62'd0, err_cause}, 64'd1);
    chk("mis_ready", {63'd0, in_ready}, 64'd1);

    // Reset clears the sticky error
    rst = 1'b0; exp_q.delete();
    @(negedge clk); rst = 1'b1;
    chk("rst2_err", {63'd0, mem_err}, 64'd0);
    chk("rst2_cause", {62'd0, err_cause}, 64'd0);

    // Timeout: no ack for 4 WAIT cycles
    drive(32'h20, 32'h0, 32'h500, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); idle();
      chk($sformatf("to_req_c%0d", i), {63'd0, mem_req}, 64'd1);
    end
    @(negedge clk);
    chk("to_req_drop", {63'd0, mem_req}, 64'd0);
    chk("to_err", {63'd0, mem_err}, 64'd1);
    chk("to_cause", {62'd0, err_cause}, 64'd2);
    @(negedge clk);
    chk("to_valid", {63'd0, out_valid}, 64'd1);

    // Later misaligned store keeps the first cause
    drive(32'h2, 32'h77, 32'h504, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk); idle();
    chk("mis2_valid", {63'd0, out_valid}, 64'd1);
    chk("mis2_req", {63'd0, mem_req}, 64'd0);
    chk("mis2_cause_kept", {62'd0, err_cause}, 64'd2);

    rst = 1'b0; exp_q.delete();
    @(negedge clk); rst = 1'b1;

    // Ack on the expiry cycle wins
    drive(32'h40, 32'h0, 32'h600, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 1'b1);
    @(negedge clk); idle();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("race_req", {63'd0, mem_req}, 64'd1);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk); mem_ack = 1'b0;
    chk("race_req_drop", {63'd0, mem_req}, 64'd0);
    chk("race_no_err", {63'd0, mem_err}, 64'd0);
    @(negedge clk);
    chk("race_valid", {63'd0, out_valid}, 64'd1);
    chk("race_cause", {62'd0, err_cause}, 64'd0);

    // Reset during WAIT, then a late ack
    drive(32'h50, 32'h0, 32'h700, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk); idle();
    chk("rw_req", {63'd0, mem_req}, 64'd1);
    rst = 1'b0; exp_q.delete();
    @(negedge clk); rst = 1'b1;
    chk("rw_req0", {63'd0, mem_req}, 64'd0);
    chk("rw_ready", {63'd0, in_ready}, 64'd1);
    chk("rw_valid0", {63'd0, out_valid}, 64'd0);
    chk("rw_alu0", {32'd0, out_aluResult}, 64'd0);
    chk("rw_ld0", {32'd0, out_ldResult}, 64'd0);
    chk("rw_pc0", {32'd0, out_pc}, 64'd0);
    chk("rw_addr0", {48'd0, mem_addr}, 64'd0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk); mem_ack = 1'b0;
    chk("rw_late_ack_valid", {63'd0, out_valid}, 64'd0);
    chk("rw_late_ack_req", {63'd0, mem_req}, 64'd0);
    @(negedge clk);
    chk("rw_late_ack_valid2", {63'd0, out_valid}, 64'd0);
    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
